// File: rtl/div8by4_seq.sv
// div8by4_seq: sequential restoring divider, STEP quotient bits per cycle,
// valid/ready operand port in, valid/ready result port out.
module div8by4_seq #(
  parameter int DW   = 8,
  parameter int VW   = 4,
  parameter int STEP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int NIT = DW / STEP;
  localparam int CW  = (NIT > 1) ? $clog2(NIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   r_sh;
  logic [VW-1:0] r_nx;
  logic [DW-1:0] q_nx;
  logic          acc;

  assign in_ready    = (state_q == IDLE) && !rst;
  assign acc         = in_valid && in_ready;
  assign out_valid   = vld_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // Between steps R < D, so only the shifted R' needs the extra bit.
  always_comb begin
    r_nx = r_q;
    q_nx = q_q;
    r_sh = '0;
    for (int i = 0; i < STEP; i++) begin
      r_sh = {r_nx, q_nx[DW-1]};
      q_nx = {q_nx[DW-2:0], 1'b0};
      if (r_sh >= {1'b0, d_q}) begin
        r_sh    = r_sh - {1'b0, d_q};
        q_nx[0] = 1'b1;
      end
      r_nx = r_sh[VW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    vld_d   = vld_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          cnt_d   = '0;
          zero_d  = (divisor == '0);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (zero_q) begin
          quo_d   = '1;
          rem_d   = '1;
          dbz_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = r_nx;
          q_d   = q_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            quo_d   = q_nx;
            rem_d   = r_nx;
            dbz_d   = 1'b0;
            vld_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_div8by4_seq.sv
// tb_div8by4_seq: directed and exhaustive checks of div8by4_seq.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_div8by4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div8by4_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    dividend = 8'd20; divisor = 4'd3;
    tick(); tick();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
    end
    total++;
    if ({out_valid, quotient, remainder, div_by_zero} !== 14'd0) begin
      bad++;
      $display("FAIL rst_outputs: got v=%b q=%0d r=%0d z=%b want all 0",
               out_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    dividend = 8'd200; divisor = 4'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; dividend = 8'd0; divisor = 4'd1;
    for (int k = 1; k <= 3; k++) begin
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL basic_busy%0d: got v=%b rdy=%b want 0 0",
                 k, out_valid, in_ready);
      end
      tick();
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_busy_ready: got %b want 0", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || quotient !== 8'd28 || remainder !== 4'd4 ||
        div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got v=%b q=%0d r=%0d z=%b want 1 28 4 0",
               out_valid, quotient, remainder, div_by_zero);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_done_ready: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_handshake: got v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_edges();
    logic [7:0] ta [5] = '{8'd255, 8'd0, 8'd15, 8'd14, 8'd255};
    logic [3:0] tb [5] = '{4'd1, 4'd9, 4'd15, 4'd15, 4'd15};
    logic [7:0] tq [5] = '{8'd255, 8'd0, 8'd1, 8'd0, 8'd17};
    logic [3:0] tr [5] = '{4'd0, 4'd0, 4'd0, 4'd14, 4'd0};
    int lat;
    // out_ready held high early must not matter before out_valid
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dividend = ta[i]; divisor = tb[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (out_valid === 1'b1) begin
          lat = k;
          break;
        end
      end
      total++;
      if (lat != 4 || quotient !== tq[i] || remainder !== tr[i] ||
          div_by_zero !== 1'b0) begin
        bad++;
        $display("FAIL edge%0d %0d/%0d: got lat=%0d q=%0d r=%0d z=%b want 4 %0d %0d 0",
                 i, ta[i], tb[i], lat, quotient, remainder, div_by_zero,
                 tq[i], tr[i]);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL edge%0d_release: got v=%b rdy=%b want 0 1",
                 i, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_div_zero();
    dividend = 8'd13; divisor = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL dz_early: got v=%b want 0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || quotient !== 8'hFF || remainder !== 4'hF ||
        div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dz_result: got v=%b q=%h r=%h z=%b want 1 ff f 1",
               out_valid, quotient, remainder, div_by_zero);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    dividend = 8'd100; divisor = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    total++;
    if (out_valid !== 1'b1 || quotient !== 8'd33 || remainder !== 4'd1 ||
        div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL dz_next: got v=%b q=%0d r=%0d z=%b want 1 33 1 0",
               out_valid, quotient, remainder, div_by_zero);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int seen;
    dividend = 8'd77; divisor = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3);
      if (c == 3) begin
        dividend = 8'd50; divisor = 4'd5;
      end
      total++;
      if (out_valid !== 1'b1 || quotient !== 8'd15 || remainder !== 4'd2 ||
          in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b q=%0d r=%0d rdy=%b want 1 15 2 0",
                 c, out_valid, quotient, remainder, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL bp_single: got %0d extra valid cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    dividend = 8'd180; divisor = 4'd11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, quotient, remainder, div_by_zero} !== 14'd0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_reset: got v=%b q=%0d r=%0d z=%b rdy=%b want 0 0 0 0 1",
               out_valid, quotient, remainder, div_by_zero, in_ready);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rmid_ghost: got %0d valid cycles want 0", seen);
    end
    dividend = 8'd180; divisor = 4'd11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_early: got v=%b want 0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || quotient !== 8'd16 || remainder !== 4'd4) begin
      bad++;
      $display("FAIL rmid_redo: got v=%b q=%0d r=%0d want 1 16 4",
               out_valid, quotient, remainder);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_exhaustive();
    int results;
    int accepted;
    bit got;
    results  = 0;
    accepted = 0;
    for (int d = 0; d < 16; d++) begin
      for (int n = 0; n < 256; n++) begin
        dividend = 8'(n); divisor = 4'(d); in_valid = 1'b1;
        for (int w = 0; w < 20 && in_ready !== 1'b1; w++) tick();
        tick();
        in_valid = 1'b0;
        accepted++;
        got = 1'b0;
        for (int w = 0; w < 40; w++) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got = 1'b1;
            results++;
            total++;
            if (d == 0) begin
              if (div_by_zero !== 1'b1 || quotient !== 8'hFF ||
                  remainder !== 4'hF) begin
                bad++;
                $display("FAIL ex %0d/0: got q=%h r=%h z=%b want ff f 1",
                         n, quotient, remainder, div_by_zero);
              end
            end else if (div_by_zero !== 1'b0 ||
                         int'(quotient) * d + int'(remainder) != n ||
                         int'(remainder) >= d) begin
              bad++;
              $display("FAIL ex %0d/%0d: got q=%0d r=%0d z=%b want q*d+r=%0d r<%0d",
                       n, d, quotient, remainder, div_by_zero, n, d);
            end
            tick();
            break;
          end
          tick();
        end
        out_ready = 1'b0;
        if (!got) begin
          total++; bad++;
          $display("FAIL ex_timeout %0d/%0d: got no result want one", n, d);
        end
      end
    end
    total++;
    if (results != accepted || results != 4096) begin
      bad++;
      $display("FAIL ex_count: got %0d results for %0d accepts want 4096",
               results, accepted);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
